data_plane_fifo_mc: RTL and testbench
=====================================

Name: data_plane_fifo_mc

Overview:
Second-generation data plane for a communications-processor node: parametrised TX and RX buffers in one block, each a circular FIFO, with multi-word bursts.
- TX: GPP loads words into the TX FIFO, then the control plane triggers a burst of addressed packets.
- RX: packets addressed to this node are filtered into the RX FIFO; the GPP drains it; end of burst is signalled to the control plane.
- Adds over the first generation: destination addressing, last-word framing, occupancy reporting and overflow detection.

Parameters:
DATA_W, 16, payload width per packet.
ID_W, 8, node-id width.
DEPTH, 16, words per FIFO (power of two, ≥2).
PKT_W, DATA_W+ID_W+2, packet width (derived; do not override).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
node_id  in  ID_W  this node's id
gpp_trf_dp  in  1  GPP write strobe into TX FIFO
gpp_tx_data  in  DATA_W  word to write
tx_dest_id  in  ID_W  burst destination, sampled on data_tx_flag
data_tx_flag  in  1  control-plane start-burst pulse
data_tx_complete_flag  out  1  one-cycle pulse, burst finished
data_tx_packet  out  PKT_W  outgoing packet
tx_busy  out  1  burst in progress
tx_count  out  $clog2(DEPTH)+1  TX FIFO occupancy
data_rx_packet  in  PKT_W  incoming packet
gpp_rtr_dp  in  1  GPP read strobe from RX FIFO
RAM_rx_data_out  out  DATA_W  read data
rx_data_valid  out  1  RAM_rx_data_out valid this cycle
data_rx_complete_flag  out  1  one-cycle pulse, last word received
rx_count  out  $clog2(DEPTH)+1  RX FIFO occupancy
rx_overflow  out  1  sticky: an addressed word was dropped

Behaviour:
- Packet format: [PKT_W-1] valid, [PKT_W-2] last, [PKT_W-3 -: ID_W] dest id, [DATA_W-1:0] payload.
- Reset (synchronous): all outputs 0, both FIFOs empty, pointers 0, TX FSM to IDLE, rx_overflow cleared.

TX FSM: IDLE, SEND, DONE.
- IDLE:
  - gpp_trf_dp with tx_count<DEPTH pushes gpp_tx_data; writes when full are dropped.
  - data_tx_flag latches tx_dest_id.
  - data_tx_flag with tx_count>0 goes to SEND; with tx_count==0 goes straight to DONE and no packets are emitted.
- SEND:
  - One packet per cycle, registered; the first packet appears the cycle after data_tx_flag.
  - Each packet: valid=1, dest=latched id, payload=FIFO head; the FIFO is popped.
  - last=1 on the packet that empties the FIFO, then go to DONE.
  - tx_busy=1.
  - gpp_trf_dp is ignored (word dropped).
  - data_tx_flag is ignored.
- DONE:
  - data_tx_complete_flag=1 for exactly one cycle; data_tx_packet=0; next state is IDLE.
  - tx_busy=1.
  - gpp_trf_dp is ignored (word dropped).
  - data_tx_flag is ignored.
- data_tx_packet is 0 whenever not emitting.
- Pointers wrap modulo DEPTH.
- A DEPTH-word burst takes DEPTH cycles of packets plus one DONE cycle.

RX:
- Accept: valid=1 and dest==node_id. Everything else is ignored.
- Accepted word with rx_count<DEPTH: pushed the same edge.
- Accepted word with rx_count==DEPTH: dropped, rx_overflow set (held until rst).
- Accepted word with last=1: data_rx_complete_flag pulses for one cycle on the following cycle, whether or not the word was dropped.
- gpp_rtr_dp with rx_count>0: pops; RAM_rx_data_out updates next cycle with rx_data_valid=1 for one cycle.
- gpp_rtr_dp with rx_count==0: no effect, rx_data_valid=0.
- RAM_rx_data_out holds its last value otherwise.
- Simultaneous push and pop: both happen; rx_count unchanged; a full FIFO with a pop accepts the push (no overflow).
- Read-during-write to the same slot is not possible: the pop reads the old head.
- TX and RX are fully independent; loopback of data_tx_packet to data_rx_packet must work.

Test Plan:
- Write 3 words 0x1111, 0x2222, 0x3333; pulse data_tx_flag with tx_dest_id=0x05 → next 3 cycles packets {1,0,05,1111}, {1,0,05,2222}, {1,1,05,3333}; complete pulses the following cycle; tx_count=0.
- data_tx_flag with an empty TX FIFO → no valid packets; data_tx_complete_flag pulses once, 1 cycle later.
- node_id=0x05: drive 4 packets, dest 05, 07, 05 (last), invalid 05 → rx_count=2; complete pulses once; two gpp_rtr_dp reads return words 1 then 3 with rx_data_valid.
- Fill RX with DEPTH addressed words, send one more → rx_overflow=1, rx_count=DEPTH; same extra word with a concurrent gpp_rtr_dp → no overflow.
- Fill TX to DEPTH, write an extra word → dropped; burst emits exactly DEPTH packets; gpp_trf_dp during SEND is ignored.
- Assert rst mid-burst (SEND) and mid-receive → next cycle all outputs 0, counts 0, no complete pulse.

Source files
------------

// File: rtl/data_plane_fifo_mc.sv
// Dual-FIFO data plane: a TX burst engine emitting addressed, framed packets
// and an address-filtering RX buffer with occupancy and overflow reporting.
module data_plane_fifo_mc #(
  parameter  int DATA_W = 16,
  parameter  int ID_W   = 8,
  parameter  int DEPTH  = 16,
  localparam int PKT_W  = DATA_W + ID_W + 2,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   node_id,
  input  logic              gpp_trf_dp,
  input  logic [DATA_W-1:0] gpp_tx_data,
  input  logic [ID_W-1:0]   tx_dest_id,
  input  logic              data_tx_flag,
  output logic              data_tx_complete_flag,
  output logic [PKT_W-1:0]  data_tx_packet,
  output logic              tx_busy,
  output logic [CNT_W-1:0]  tx_count,
  input  logic [PKT_W-1:0]  data_rx_packet,
  input  logic              gpp_rtr_dp,
  output logic [DATA_W-1:0] RAM_rx_data_out,
  output logic              rx_data_valid,
  output logic              data_rx_complete_flag,
  output logic [CNT_W-1:0]  rx_count,
  output logic              rx_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE} tx_state_t;

  tx_state_t         tx_state;
  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [PTR_W-1:0]  tx_wr_ptr;
  logic [PTR_W-1:0]  tx_rd_ptr;
  logic [ID_W-1:0]   tx_dest_q;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_last;
  logic [DATA_W-1:0] tx_head;

  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [PTR_W-1:0]  rx_wr_ptr;
  logic [PTR_W-1:0]  rx_rd_ptr;
  logic              rx_accept;
  logic              rx_push;
  logic              rx_pop;

  // The GPP may only load the TX FIFO while no burst is running; the first
  // packet of a burst is popped on the same edge that accepts the start pulse.
  assign tx_push = (tx_state == TX_IDLE) && gpp_trf_dp && (tx_count != FULL);
  assign tx_pop  = (tx_count != '0) &&
                   (((tx_state == TX_IDLE) && data_tx_flag) || (tx_state == TX_SEND));
  assign tx_last = (tx_count == ONE) && !tx_push;
  assign tx_head = tx_mem[tx_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && tx_push) begin
      tx_mem[tx_wr_ptr] <= gpp_tx_data;
    end
  end

  // Outputs are registered alongside the state, so the visible state always
  // matches what is on the packet/complete outputs in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state              <= TX_IDLE;
      tx_wr_ptr             <= '0;
      tx_rd_ptr             <= '0;
      tx_count              <= '0;
      tx_dest_q             <= '0;
      tx_busy               <= 1'b0;
      data_tx_packet        <= '0;
      data_tx_complete_flag <= 1'b0;
    end else begin
      if (tx_push) begin
        tx_wr_ptr <= tx_wr_ptr + 1'b1;
      end
      if (tx_pop) begin
        tx_rd_ptr <= tx_rd_ptr + 1'b1;
      end
      tx_count              <= tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
      data_tx_packet        <= '0;
      data_tx_complete_flag <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (data_tx_flag) begin
            tx_dest_q <= tx_dest_id;
            tx_busy   <= 1'b1;
            if (tx_pop) begin
              data_tx_packet <= {1'b1, tx_last, tx_dest_id, tx_head};
              tx_state       <= TX_SEND;
            end else begin
              data_tx_complete_flag <= 1'b1;
              tx_state              <= TX_DONE;
            end
          end
        end
        TX_SEND: begin
          if (tx_pop) begin
            data_tx_packet <= {1'b1, tx_last, tx_dest_q, tx_head};
          end else begin
            data_tx_complete_flag <= 1'b1;
            tx_state              <= TX_DONE;
          end
        end
        TX_DONE: begin
          tx_busy  <= 1'b0;
          tx_state <= TX_IDLE;
        end
        default: begin
          tx_busy  <= 1'b0;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // A pop frees a slot on the same edge, so a full FIFO being read still
  // takes the incoming word instead of flagging overflow.
  assign rx_accept = data_rx_packet[PKT_W-1] &&
                     (data_rx_packet[PKT_W-3 -: ID_W] == node_id);
  assign rx_pop    = gpp_rtr_dp && (rx_count != '0);
  assign rx_push   = rx_accept && ((rx_count != FULL) || rx_pop);

  always_ff @(posedge clk) begin
    if (!rst && rx_push) begin
      rx_mem[rx_wr_ptr] <= data_rx_packet[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr             <= '0;
      rx_rd_ptr             <= '0;
      rx_count              <= '0;
      RAM_rx_data_out       <= '0;
      rx_data_valid         <= 1'b0;
      data_rx_complete_flag <= 1'b0;
      rx_overflow           <= 1'b0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr <= rx_wr_ptr + 1'b1;
      end
      if (rx_pop) begin
        rx_rd_ptr       <= rx_rd_ptr + 1'b1;
        RAM_rx_data_out <= rx_mem[rx_rd_ptr];
      end
      rx_count              <= rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);
      rx_data_valid         <= rx_pop;
      data_rx_complete_flag <= rx_accept && data_rx_packet[PKT_W-2];
      if (rx_accept && !rx_push) begin
        rx_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_plane_fifo_mc.sv
// Scoreboard bench for data_plane_fifo_mc: a queue-level reference model
// schedules expected outputs per clock edge; a monitor consumes them.
module tb_data_plane_fifo_mc;

  localparam int DATA_W = 16;
  localparam int ID_W   = 8;
  localparam int DEPTH  = 16;
  localparam int PKT_W  = DATA_W + ID_W + 2;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [ID_W-1:0]   node_id;
  logic              gpp_trf_dp;
  logic [DATA_W-1:0] gpp_tx_data;
  logic [ID_W-1:0]   tx_dest_id;
  logic              data_tx_flag;
  logic              data_tx_complete_flag;
  logic [PKT_W-1:0]  data_tx_packet;
  logic              tx_busy;
  logic [CNT_W-1:0]  tx_count;
  logic [PKT_W-1:0]  data_rx_packet;
  logic              gpp_rtr_dp;
  logic [DATA_W-1:0] RAM_rx_data_out;
  logic              rx_data_valid;
  logic              data_rx_complete_flag;
  logic [CNT_W-1:0]  rx_count;
  logic              rx_overflow;

  logic [PKT_W-1:0]  rx_pkt_drv;
  logic              loopback;

  assign data_rx_packet = loopback ? data_tx_packet : rx_pkt_drv;

  data_plane_fifo_mc #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .node_id(node_id),
    .gpp_trf_dp(gpp_trf_dp), .gpp_tx_data(gpp_tx_data), .tx_dest_id(tx_dest_id),
    .data_tx_flag(data_tx_flag), .data_tx_complete_flag(data_tx_complete_flag),
    .data_tx_packet(data_tx_packet), .tx_busy(tx_busy), .tx_count(tx_count),
    .data_rx_packet(data_rx_packet), .gpp_rtr_dp(gpp_rtr_dp),
    .RAM_rx_data_out(RAM_rx_data_out), .rx_data_valid(rx_data_valid),
    .data_rx_complete_flag(data_rx_complete_flag), .rx_count(rx_count),
    .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stamp;
    logic [63:0] val;
  } ev_t;

  typedef struct {
    int                stamp;
    int                txc;
    int                rxc;
    logic              busy;
    logic              ovf;
    logic [DATA_W-1:0] rdata;
  } st_t;

  // Event kinds: 0 tx packet, 1 tx complete, 2 rx read, 3 rx complete.
  ev_t   evq [4][$];
  st_t   stq [$];
  string evname [4] = '{"tx_packet", "tx_complete", "rx_read", "rx_complete"};

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DATA_W-1:0] m_txq [$];
  logic [DATA_W-1:0] m_rxq [$];
  logic [PKT_W-1:0]  m_sched [int];
  int                m_burst_start = -1000;
  int                m_burst_n     = 0;
  int                m_tx_free     = 0;
  logic              m_ovf         = 1'b0;
  logic [DATA_W-1:0] m_rdata       = '0;

  logic              r_rst, r_trf, r_flag, r_rtr, r_v, r_l;
  logic [ID_W-1:0]   r_d;

  function automatic logic [PKT_W-1:0] mk(logic v, logic l, logic [ID_W-1:0] d,
                                          logic [DATA_W-1:0] w);
    return {v, l, d, w};
  endfunction

  function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flagError(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void addEvent(int kind, int stamp, logic [63:0] v);
    ev_t e;
    e.stamp = stamp;
    e.val   = v;
    evq[kind].push_back(e);
  endfunction

  // Reference model for one clock edge e: whole bursts are scheduled at once
  // from the queued words; RX is a bounded queue with a sticky drop flag.
  function automatic void modelEdge(int e, logic r, logic trf, logic [DATA_W-1:0] txd,
                                    logic [ID_W-1:0] dest, logic flag,
                                    logic [PKT_W-1:0] rxp, logic rtr);
    st_t s;
    int  n;
    logic idle;
    logic [PKT_W-1:0] pkt;
    if (r) begin
      m_txq.delete();
      m_rxq.delete();
      m_sched.delete();
      m_burst_start = -1000;
      m_burst_n     = 0;
      m_tx_free     = 0;
      m_ovf         = 1'b0;
      m_rdata       = '0;
      for (int k = 0; k < 4; k++) begin
        while (evq[k].size() > 0 && evq[k][$].stamp >= e) void'(evq[k].pop_back());
      end
      s = '{e, 0, 0, 1'b0, 1'b0, '0};
      stq.push_back(s);
      return;
    end
    idle = (e >= m_tx_free);
    if (idle && flag) begin
      n = m_txq.size();
      for (int j = 0; j < n; j++) begin
        pkt = mk(1'b1, (j == n - 1), dest, m_txq[j]);
        addEvent(0, e + j, 64'(pkt));
        m_sched[e + j] = pkt;
      end
      addEvent(1, e + n, 64'd1);
      m_burst_start = e;
      m_burst_n     = n;
      m_tx_free     = e + n + 2;
      m_txq.delete();
    end else if (idle && trf && m_txq.size() < DEPTH) begin
      m_txq.push_back(txd);
    end
    if (rtr && m_rxq.size() > 0) begin
      m_rdata = m_rxq.pop_front();
      addEvent(2, e, 64'(m_rdata));
    end
    if (rxp[PKT_W-1] && rxp[PKT_W-3 -: ID_W] == node_id) begin
      if (m_rxq.size() < DEPTH) m_rxq.push_back(rxp[DATA_W-1:0]);
      else m_ovf = 1'b1;
      if (rxp[PKT_W-2]) addEvent(3, e, 64'd1);
    end
    s.stamp = e;
    s.txc   = (e >= m_burst_start && e < m_burst_start + m_burst_n) ?
              m_burst_n - 1 - (e - m_burst_start) : m_txq.size();
    s.rxc   = m_rxq.size();
    s.busy  = (e >= m_burst_start) && (e <= m_burst_start + m_burst_n);
    s.ovf   = m_ovf;
    s.rdata = m_rdata;
    stq.push_back(s);
  endfunction

  task automatic applyStimulus(logic r, logic trf, logic [DATA_W-1:0] txd,
                               logic [ID_W-1:0] dest, logic flag,
                               logic [PKT_W-1:0] rxp, logic rtr);
    logic [PKT_W-1:0] eff;
    rst          = r;
    gpp_trf_dp   = trf;
    gpp_tx_data  = txd;
    tx_dest_id   = dest;
    data_tx_flag = flag;
    rx_pkt_drv   = rxp;
    gpp_rtr_dp   = rtr;
    eff = loopback ? (m_sched.exists(cyc) ? m_sched[cyc] : '0) : rxp;
    modelEdge(cyc + 1, r, trf, txd, dest, flag, eff, rtr);
    @(negedge clk);
  endtask

  task automatic applyIdle(int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  function automatic void monitorCycle();
    logic        present [4];
    logic [63:0] act [4];
    st_t         s;
    present[0] = data_tx_packet[PKT_W-1];
    act[0]     = 64'(data_tx_packet);
    present[1] = data_tx_complete_flag;
    act[1]     = 64'd1;
    present[2] = rx_data_valid;
    act[2]     = 64'(RAM_rx_data_out);
    present[3] = data_rx_complete_flag;
    act[3]     = 64'd1;
    for (int k = 0; k < 4; k++) begin
      if (present[k]) begin
        if (evq[k].size() > 0 && evq[k][0].stamp == cyc) begin
          checkOutput(evname[k], act[k], evq[k][0].val);
          void'(evq[k].pop_front());
        end else begin
          flagError({evname[k], " unexpected"}, act[k], 64'd0);
        end
      end else if (evq[k].size() > 0 && evq[k][0].stamp == cyc) begin
        flagError({evname[k], " missing"}, 64'd0, evq[k][0].val);
        void'(evq[k].pop_front());
      end
    end
    if (!data_tx_packet[PKT_W-1]) checkOutput("tx_packet idle zero", 64'(data_tx_packet), 64'd0);
    if (stq.size() > 0) begin
      s = stq.pop_front();
      checkOutput("tx_count", 64'(tx_count), 64'(s.txc));
      checkOutput("rx_count", 64'(rx_count), 64'(s.rxc));
      checkOutput("tx_busy", 64'(tx_busy), 64'(s.busy));
      checkOutput("rx_overflow", 64'(rx_overflow), 64'(s.ovf));
      checkOutput("RAM_rx_data_out", 64'(RAM_rx_data_out), 64'(s.rdata));
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    #1;
    monitorCycle();
  end

  initial begin
    loopback = 1'b0;
    node_id  = 8'h05;
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkOutput("reset tx_count", 64'(tx_count), 64'd0);
    checkOutput("reset rx_overflow", 64'(rx_overflow), 64'd0);
    applyIdle(1);

    $display("[TB] three-word burst");
    applyStimulus(1'b0, 1'b1, 16'h1111, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h2222, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h3333, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 8'h05, 1'b1, '0, 1'b0);
    checkOutput("plan pkt1", 64'(data_tx_packet), 64'(mk(1'b1, 1'b0, 8'h05, 16'h1111)));
    applyIdle(1);
    checkOutput("plan pkt2", 64'(data_tx_packet), 64'(mk(1'b1, 1'b0, 8'h05, 16'h2222)));
    applyIdle(1);
    checkOutput("plan pkt3", 64'(data_tx_packet), 64'(mk(1'b1, 1'b1, 8'h05, 16'h3333)));
    applyIdle(1);
    checkOutput("plan tx complete", 64'(data_tx_complete_flag), 64'd1);
    checkOutput("plan tx_count", 64'(tx_count), 64'd0);
    applyIdle(2);

    $display("[TB] empty burst");
    applyStimulus(1'b0, 1'b0, '0, 8'h09, 1'b1, '0, 1'b0);
    checkOutput("empty burst complete", 64'(data_tx_complete_flag), 64'd1);
    applyIdle(3);

    $display("[TB] rx filtering");
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, mk(1'b1, 1'b0, 8'h05, 16'h0001), 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, mk(1'b1, 1'b0, 8'h07, 16'h0002), 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, mk(1'b1, 1'b1, 8'h05, 16'h0003), 1'b0);
    checkOutput("plan rx complete", 64'(data_rx_complete_flag), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, mk(1'b0, 1'b0, 8'h05, 16'h0004), 1'b0);
    checkOutput("plan rx_count", 64'(rx_count), 64'd2);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    checkOutput("plan rx read1", 64'(RAM_rx_data_out), 64'h0001);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    checkOutput("plan rx read2", 64'(RAM_rx_data_out), 64'h0003);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    checkOutput("read of empty rx", 64'(rx_data_valid), 64'd0);
    applyIdle(2);

    $display("[TB] rx overflow");
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, mk(1'b1, 1'b0, 8'h05, 16'(16'h0100 + i)), 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, mk(1'b1, 1'b0, 8'h05, 16'hBEEF), 1'b0);
    checkOutput("overflow set", 64'(rx_overflow), 64'd1);
    checkOutput("overflow rx_count", 64'(rx_count), 64'(DEPTH));
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, mk(1'b1, 1'b0, 8'h05, 16'(16'h0200 + i)), 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, mk(1'b1, 1'b0, 8'h05, 16'hBEEF), 1'b1);
    checkOutput("full with pop no overflow", 64'(rx_overflow), 64'd0);
    checkOutput("full with pop rx_count", 64'(rx_count), 64'(DEPTH));
    checkOutput("full with pop read", 64'(RAM_rx_data_out), 64'h0200);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    applyIdle(1);

    $display("[TB] full tx burst");
    for (int i = 0; i <= DEPTH; i++)
      applyStimulus(1'b0, 1'b1, 16'(16'hA000 + i), '0, 1'b0, '0, 1'b0);
    checkOutput("tx full count", 64'(tx_count), 64'(DEPTH));
    applyStimulus(1'b0, 1'b0, '0, 8'h22, 1'b1, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b1, 16'hDEAD, 8'h33, 1'b1, '0, 1'b0);
    checkOutput("tx count after full burst", 64'(tx_count), 64'd0);
    applyIdle(3);

    $display("[TB] reset mid-burst and mid-receive");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b1, 16'(16'hC000 + i), '0, 1'b0,
                    mk(1'b1, 1'b0, 8'h05, 16'(16'h0300 + i)), 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 8'h05, 1'b1, '0, 1'b0);
    applyIdle(1);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, mk(1'b1, 1'b1, 8'h05, 16'h0399), 1'b1);
    checkOutput("rst tx_packet", 64'(data_tx_packet), 64'd0);
    checkOutput("rst tx_busy", 64'(tx_busy), 64'd0);
    checkOutput("rst tx_count", 64'(tx_count), 64'd0);
    checkOutput("rst rx_count", 64'(rx_count), 64'd0);
    checkOutput("rst rx complete", 64'(data_rx_complete_flag), 64'd0);
    checkOutput("rst rx_data_valid", 64'(rx_data_valid), 64'd0);
    applyIdle(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      r_rst  = ($urandom_range(0, 399) == 0);
      r_flag = ($urandom_range(0, 15) == 0);
      r_trf  = !r_flag && ($urandom_range(0, 2) != 0);
      r_rtr  = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      r_v    = ($urandom_range(0, 3) != 0);
      r_l    = ($urandom_range(0, 4) == 0);
      r_d    = ($urandom_range(0, 2) != 0) ? node_id : 8'($urandom_range(0, 255));
      applyStimulus(r_rst, r_trf, 16'($urandom), 8'($urandom), r_flag,
                    mk(r_v, r_l, r_d, 16'($urandom)), r_rtr);
    end
    applyIdle(DEPTH + 4);

    $display("[TB] loopback");
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    loopback = 1'b1;
    node_id  = 8'h3C;
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 1'b1, 16'(16'h5A00 + i), '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 8'h3C, 1'b1, '0, 1'b0);
    applyIdle(10);
    checkOutput("loopback rx_count", 64'(rx_count), 64'd6);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    applyIdle(DEPTH + 4);

    for (int k = 0; k < 4; k++)
      checkOutput({evname[k], " leftover"}, 64'(evq[k].size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
